// File: rtl/sram8_bus_target_pkg.sv
// -----------------------------------------------------------------------------
// sram8_bus_target_pkg
//   Shared types and constants for the word-bus to 8-bit SRAM bridge:
//   controller state encoding, byte-lane offsets and the all-ones fill
//   patterns returned for lanes that were not read.
// -----------------------------------------------------------------------------
package sram8_bus_target_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_HOLD   = 2'd2,
        ST_DONE   = 2'd3
    } t_sram8_state;

    // Byte offset within the word; strobe[3] / data[31:24] is offset 0.
    localparam logic [1:0] LANE_OFFSET_0 = 2'd0;
    localparam logic [1:0] LANE_OFFSET_1 = 2'd1;
    localparam logic [1:0] LANE_OFFSET_2 = 2'd2;
    localparam logic [1:0] LANE_OFFSET_3 = 2'd3;

    localparam logic [7:0]  BYTE_FILL = 8'hff;
    localparam logic [31:0] WORD_FILL = {4{BYTE_FILL}};

endpackage

// File: rtl/sram8_bus_target_strobe_lane_select.sv
// -----------------------------------------------------------------------------
// sram8_bus_target_strobe_lane_select
//   Combinational priority encoder: picks the highest-set pending strobe
//   (lowest byte offset) as the next lane to access.
// Ports
//   pending     in   4   byte-lane strobes still to be serviced
//   wdata       in   32  write word, big-endian lanes
//   lane_offset out  2   byte offset of the selected lane
//   lane_mask   out  4   one-hot mask of the selected lane (strobe order)
//   lane_byte   out  8   write byte of the selected lane (8'hff if none)
// -----------------------------------------------------------------------------
module sram8_bus_target_strobe_lane_select
    import sram8_bus_target_pkg::*;
(
    input  logic [3:0]  pending,
    input  logic [31:0] wdata,
    output logic [1:0]  lane_offset,
    output logic [3:0]  lane_mask,
    output logic [7:0]  lane_byte
);

    // NOTE: every output gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        lane_offset = LANE_OFFSET_0;
        lane_mask   = 4'b0000;
        lane_byte   = BYTE_FILL;
        casez (pending)
            4'b1???: begin lane_offset = LANE_OFFSET_0; lane_mask = 4'b1000; lane_byte = wdata[31:24]; end
            4'b01??: begin lane_offset = LANE_OFFSET_1; lane_mask = 4'b0100; lane_byte = wdata[23:16]; end
            4'b001?: begin lane_offset = LANE_OFFSET_2; lane_mask = 4'b0010; lane_byte = wdata[15:8];  end
            4'b0001: begin lane_offset = LANE_OFFSET_3; lane_mask = 4'b0001; lane_byte = wdata[7:0];   end
            default: ;
        endcase
    end

endmodule

// File: rtl/sram8_bus_target.sv
// -----------------------------------------------------------------------------
// sram8_bus_target
//   Responder end of the CPU word bus. Each strobed byte lane of a request
//   becomes one access on an 8-bit asynchronous SRAM; the read word is
//   assembled lane by lane and a one-cycle ready (plus error) is returned.
//
// Parameters
//   ADDR_WIDTH   SRAM byte-address width; higher bus address bits alias
//   WAIT_STATES  extra cycles each SRAM strobe is held beyond the first (0..15)
//
// Ports
//   clock, reset               system clock; asynchronous active-high reset
//   target_address[29:0]       word address (byte address bits [31:2])
//   target_data_in[31:0]       write data, strobe[3] = [31:24] = offset 0
//   target_data_strobes[3:0]   byte-lane enables
//   target_read/target_write   request, held by initiator until ready
//   target_data_out[31:0]      read word while ready; unread lanes 8'hff
//   target_ready/target_error  one-cycle completion / illegal-request pulse
//   sram_address, sram_data_out, sram_data_in, sram_data_oe,
//   sram_ce_n, sram_oe_n, sram_we_n   external SRAM pins
//
// Configuration
//   SRAM8_FAST_READ_EN  when defined, read lanes follow each other directly
//                       (ACCESS -> ACCESS, oe_n stays low); HOLD only after
//                       the final read lane. Writes always use HOLD.
// -----------------------------------------------------------------------------
module sram8_bus_target
    import sram8_bus_target_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [29:0]           target_address,
    input  logic [31:0]           target_data_in,
    input  logic [3:0]            target_data_strobes,
    input  logic                  target_read,
    input  logic                  target_write,
    output logic [31:0]           target_data_out,
    output logic                  target_ready,
    output logic                  target_error,
    output logic [ADDR_WIDTH-1:0] sram_address,
    output logic [7:0]            sram_data_out,
    input  logic [7:0]            sram_data_in,
    output logic                  sram_data_oe,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n
);

    localparam int         ROW_W     = ADDR_WIDTH - 2;
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES);

    t_sram8_state state_q, state_d;
    logic [ROW_W-1:0] addr_q, addr_d;
    logic [3:0]       pending_q, pending_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             is_write_q, is_write_d;
    logic             error_q, error_d;
    logic [1:0]       lane_q, lane_d;
    logic [3:0]       lane_mask_q, lane_mask_d;
    logic [7:0]       wbyte_q, wbyte_d;
    logic [3:0]       wait_q, wait_d;

    logic [1:0]       sel_offset;
    logic [3:0]       sel_mask;
    logic [7:0]       sel_byte;

    // Bus address bits above the SRAM window are deliberately ignored.
    logic unused_addr_hi;
    assign unused_addr_hi = ^target_address[29:ROW_W];

    logic req_any, start_access, access_last;
    assign req_any      = target_read | target_write;
    assign start_access = (state_q == ST_IDLE) && (target_read ^ target_write)
                          && (target_data_strobes != 4'b0000);
    assign access_last  = (state_q == ST_ACCESS) && (wait_q == WAIT_LAST);

    // Next pending set and write word feed the lane encoder, so the lane
    // to load on entering ACCESS is always the one still outstanding.
    always_comb begin
        pending_d = pending_q;
        wdata_d   = wdata_q;
        if (state_q == ST_IDLE && req_any) begin
            pending_d = target_data_strobes;
            wdata_d   = target_data_in;
        end else if (access_last) begin
            pending_d = pending_q & ~lane_mask_q;
        end
    end

    sram8_bus_target_strobe_lane_select u_lane_select (
        .pending     (pending_d),
        .wdata       (wdata_d),
        .lane_offset (sel_offset),
        .lane_mask   (sel_mask),
        .lane_byte   (sel_byte)
    );

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rdata_d     = rdata_q;
        is_write_d  = is_write_q;
        error_d     = error_q;
        lane_d      = lane_q;
        lane_mask_d = lane_mask_q;
        wbyte_d     = wbyte_q;
        wait_d      = wait_q;
        case (state_q)
            ST_IDLE: begin
                if (req_any) begin
                    addr_d     = target_address[ROW_W-1:0];
                    is_write_d = target_write;
                    error_d    = target_read & target_write;
                    rdata_d    = WORD_FILL;
                    if (start_access) begin
                        state_d     = ST_ACCESS;
                        lane_d      = sel_offset;
                        lane_mask_d = sel_mask;
                        wbyte_d     = sel_byte;
                        wait_d      = 4'd0;
                    end else begin
                        // Illegal or empty request: complete without SRAM activity.
                        state_d = ST_DONE;
                    end
                end
            end
            ST_ACCESS: begin
                if (!access_last) begin
                    wait_d = wait_q + 4'd1;
                end else begin
                    if (!is_write_q) begin
                        for (int i = 0; i < 4; i++) begin
                            if (lane_mask_q[i]) rdata_d[8*i +: 8] = sram_data_in;
                        end
                    end
                    state_d = ST_HOLD;
`ifdef SRAM8_FAST_READ_EN
                    if (!is_write_q && pending_d != 4'b0000) begin
                        state_d     = ST_ACCESS;
                        lane_d      = sel_offset;
                        lane_mask_d = sel_mask;
                        wbyte_d     = sel_byte;
                        wait_d      = 4'd0;
                    end
`endif
                end
            end
            ST_HOLD: begin
                if (pending_q != 4'b0000) begin
                    state_d     = ST_ACCESS;
                    lane_d      = sel_offset;
                    lane_mask_d = sel_mask;
                    wbyte_d     = sel_byte;
                    wait_d      = 4'd0;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its _d value from before this clock edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            pending_q   <= 4'b0000;
            wdata_q     <= WORD_FILL;
            rdata_q     <= WORD_FILL;
            is_write_q  <= 1'b0;
            error_q     <= 1'b0;
            lane_q      <= LANE_OFFSET_0;
            lane_mask_q <= 4'b0000;
            wbyte_q     <= BYTE_FILL;
            wait_q      <= 4'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            pending_q   <= pending_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            is_write_q  <= is_write_d;
            error_q     <= error_d;
            lane_q      <= lane_d;
            lane_mask_q <= lane_mask_d;
            wbyte_q     <= wbyte_d;
            wait_q      <= wait_d;
        end
    end

    assign sram_address = {addr_q, lane_q};

    // Outputs decoded from state; write data and its driver stay on through
    // HOLD so the SRAM sees hold time after we_n rises.
    always_comb begin
        target_ready    = 1'b0;
        target_error    = 1'b0;
        target_data_out = WORD_FILL;
        sram_ce_n       = 1'b1;
        sram_oe_n       = 1'b1;
        sram_we_n       = 1'b1;
        sram_data_oe    = 1'b0;
        sram_data_out   = BYTE_FILL;
        case (state_q)
            ST_ACCESS: begin
                sram_ce_n = 1'b0;
                if (is_write_q) begin
                    sram_we_n     = 1'b0;
                    sram_data_oe  = 1'b1;
                    sram_data_out = wbyte_q;
                end else begin
                    sram_oe_n = 1'b0;
                end
            end
            ST_HOLD: begin
                if (is_write_q) begin
                    sram_data_oe  = 1'b1;
                    sram_data_out = wbyte_q;
                end
            end
            ST_DONE: begin
                target_ready    = 1'b1;
                target_error    = error_q;
                target_data_out = rdata_q;
            end
            default: ;
        endcase
    end

endmodule
